// File: rtl/tero_eval_pkg.sv
// rtl/tero_eval_pkg.sv - shared state encoding and lane-validity helper for the TERO group evaluator
package tero_eval_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    EVAL   = 3'd2,
    ACCUM  = 3'd3,
    OUTPUT = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam int unsigned MAX_LANES = 32;

  // Bit i set when loop base+i exists; the caller slices off its own lane count.
  function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned base,
                                                     input int unsigned num_loops,
                                                     input int unsigned lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) m[i] = ((base + i) < num_loops);
    end
    return m;
  endfunction

endpackage

// File: rtl/tero_lane_accum.sv
// rtl/tero_lane_accum.sv - per-lane count accumulator with power-of-two averaging
module tero_lane_accum #(
  parameter int CNT_W      = 16,
  parameter int ACC_W      = 23,
  parameter int REP_LOG2_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [CNT_W-1:0]      cnt_in,
  input  logic [REP_LOG2_W-1:0] rep_log2,
  output logic [CNT_W-1:0]      avg
);

  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + ACC_W'(cnt_in);
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign avg = CNT_W'(acc_q >> rep_log2);

endmodule

// File: rtl/tero_group_eval_ctrl.sv
// rtl/tero_group_eval_ctrl.sv - evaluates TERO loops LANES at a time, averaging counts over 2^rep_log2 repetitions
module tero_group_eval_ctrl
  import tero_eval_pkg::*;
#(
  parameter int NUM_LOOPS  = 8,
  parameter int LANES      = 2,
  parameter int CNT_W      = 16,
  parameter int EVAL_W     = 16,
  parameter int REP_LOG2_W = 3,
  parameter int GRP_W      = $clog2(NUM_LOOPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [EVAL_W-1:0]      eval_time,
  input  logic [REP_LOG2_W-1:0]  rep_log2,
  output logic                   reset_puf,
  output logic [LANES-1:0]       enable_puf,
  output logic [GRP_W-1:0]       select_puf,
  input  logic [LANES*CNT_W-1:0] cnt_in,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [LANES*CNT_W-1:0] resp_data,
  output logic [GRP_W-1:0]       resp_index,
  output logic [LANES-1:0]       resp_lane_mask,
  output logic                   busy,
  output logic                   done
);

  localparam int ACC_W  = CNT_W + 2**REP_LOG2_W - 1;
  localparam int REP_W  = 2**REP_LOG2_W;
  // Base must hold NUM_LOOPS-1+LANES so the end-of-run test cannot wrap.
  localparam int BASE_W = $clog2(NUM_LOOPS + LANES);
  localparam logic [BASE_W-1:0] NUM_LOOPS_B = BASE_W'(NUM_LOOPS);
  localparam logic [BASE_W-1:0] LANES_B     = BASE_W'(LANES);

  state_e                  state_q;
  logic                    start_q;
  logic [EVAL_W-1:0]       eval_q;
  logic [REP_LOG2_W-1:0]   rep_log2_q;
  logic [EVAL_W-1:0]       dly_q;
  logic [REP_W-1:0]        rep_q;
  logic [BASE_W-1:0]       base_q;
  logic                    reset_puf_q;
  logic [LANES-1:0]        enable_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;

  logic [MAX_LANES-1:0]    mask_raw;
  logic                    unused_mask_bits;
  logic [LANES-1:0]        cur_mask;
  logic [EVAL_W-1:0]       eval_eff;
  logic                    rep_last;
  logic [BASE_W-1:0]       base_nxt;
  logic                    start_rise;
  logic                    in_busy;
  logic                    abort_hit;
  logic                    acc_clr;
  logic [LANES-1:0]        acc_en;
  logic [LANES*CNT_W-1:0]  lane_avg;

  assign mask_raw         = lane_mask(32'(base_q), NUM_LOOPS, LANES);
  assign unused_mask_bits = ^mask_raw;
  assign cur_mask         = mask_raw[LANES-1:0];
  assign eval_eff         = (eval_q == '0) ? EVAL_W'(1) : eval_q;
  assign rep_last         = (rep_q == ((REP_W'(1) << rep_log2_q) - REP_W'(1)));
  assign base_nxt         = base_q + LANES_B;
  assign start_rise       = start && !start_q;
  assign in_busy          = (state_q != IDLE) && (state_q != DONE);
  assign abort_hit        = abort && in_busy;
  assign acc_clr          = ((state_q == IDLE) && start_rise) || (state_q == NEXT) || abort_hit;
  assign acc_en           = (state_q == ACCUM) ? cur_mask : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tero_lane_accum #(
      .CNT_W      (CNT_W),
      .ACC_W      (ACC_W),
      .REP_LOG2_W (REP_LOG2_W)
    ) u_accum (
      .clk      (clk),
      .reset    (reset),
      .clr      (acc_clr),
      .en       (acc_en[i]),
      .cnt_in   (cnt_in[i*CNT_W +: CNT_W]),
      .rep_log2 (rep_log2_q),
      .avg      (lane_avg[i*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      eval_q      <= '0;
      rep_log2_q  <= '0;
      dly_q       <= '0;
      rep_q       <= '0;
      base_q      <= '0;
      reset_puf_q <= 1'b0;
      enable_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      start_q <= start;
      if (abort_hit) begin
        // Drop everything, including a pending response, and scrub the loops.
        state_q     <= IDLE;
        reset_puf_q <= 1'b1;
        enable_q    <= '0;
        valid_q     <= 1'b0;
        busy_q      <= 1'b0;
        dly_q       <= '0;
        rep_q       <= '0;
        base_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            reset_puf_q <= 1'b0;
            if (start_rise) begin
              eval_q      <= eval_time;
              rep_log2_q  <= rep_log2;
              base_q      <= '0;
              rep_q       <= '0;
              reset_puf_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= INIT;
            end
          end
          INIT: begin
            reset_puf_q <= 1'b0;
            enable_q    <= cur_mask;
            dly_q       <= EVAL_W'(1);
            state_q     <= EVAL;
          end
          EVAL: begin
            if (dly_q == eval_eff) begin
              enable_q <= '0;
              state_q  <= ACCUM;
            end else begin
              dly_q <= dly_q + EVAL_W'(1);
            end
          end
          ACCUM: begin
            rep_q <= rep_q + REP_W'(1);
            if (rep_last) begin
              valid_q <= 1'b1;
              state_q <= OUTPUT;
            end else begin
              reset_puf_q <= 1'b1;
              state_q     <= INIT;
            end
          end
          OUTPUT: begin
            if (resp_ready) begin
              valid_q <= 1'b0;
              state_q <= NEXT;
            end
          end
          NEXT: begin
            rep_q <= '0;
            if (base_nxt >= NUM_LOOPS_B) begin
              base_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              base_q      <= base_nxt;
              reset_puf_q <= 1'b1;
              state_q     <= INIT;
            end
          end
          DONE: begin
            if (!start) begin
              done_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign reset_puf      = reset_puf_q;
  assign enable_puf     = enable_q;
  assign select_puf     = base_q[GRP_W-1:0];
  assign resp_valid     = valid_q;
  assign resp_data      = valid_q ? lane_avg : '0;
  assign resp_index     = valid_q ? base_q[GRP_W-1:0] : '0;
  assign resp_lane_mask = valid_q ? cur_mask : '0;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_tero_group_eval_ctrl.sv
// tb/tb_tero_group_eval_ctrl.sv - directed self-checking bench for tero_group_eval_ctrl
module tb_tero_group_eval_ctrl;

  logic        clk, reset, start8, start5, abort, resp_ready;
  logic [15:0] eval_time;
  logic [2:0]  rep_log2;
  logic [31:0] cnt_in;

  logic        rp8, v8, busy8, done8;
  logic [1:0]  en8, m8;
  logic [2:0]  sel8, idx8;
  logic [31:0] d8;
  logic        rp5, v5, busy5, done5;
  logic [1:0]  en5, m5;
  logic [2:0]  sel5, idx5;
  logic [31:0] d5;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  tero_group_eval_ctrl #(.NUM_LOOPS(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .abort(abort),
    .eval_time(eval_time), .rep_log2(rep_log2),
    .reset_puf(rp8), .enable_puf(en8), .select_puf(sel8), .cnt_in(cnt_in),
    .resp_valid(v8), .resp_ready(resp_ready), .resp_data(d8), .resp_index(idx8),
    .resp_lane_mask(m8), .busy(busy8), .done(done8)
  );

  tero_group_eval_ctrl #(.NUM_LOOPS(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .abort(abort),
    .eval_time(eval_time), .rep_log2(rep_log2),
    .reset_puf(rp5), .enable_puf(en5), .select_puf(sel5), .cnt_in(cnt_in),
    .resp_valid(v5), .resp_ready(resp_ready), .resp_data(d5), .resp_index(idx5),
    .resp_lane_mask(m5), .busy(busy5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Runs until the selected DUT presents a response, tallying enable/reset activity on the way.
  task automatic run_grp(input int which, input int bound, output int en0, output int en1,
                         output int rsts, output int maxrun, output bit got);
    int run;
    logic [1:0] en;
    logic rp, v;
    en0 = 0; en1 = 0; rsts = 0; maxrun = 0; run = 0; got = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      en = which ? en5 : en8;
      rp = which ? rp5 : rp8;
      v  = which ? v5 : v8;
      if (en[0]) en0++;
      if (en[1]) en1++;
      if (rp) rsts++;
      if (en[0]) begin run++; if (run > maxrun) maxrun = run; end else run = 0;
      if (v) begin got = 1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({rp8, en8, sel8, v8, d8, idx8, m8, busy8, done8} !== 46'd0)
      $display("FAIL reset8_outputs: got %0h want 0", {rp8, en8, sel8, v8, d8, idx8, m8, busy8, done8});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({rp5, en5, sel5, v5, d5, idx5, m5, busy5, done5} !== 46'd0)
      $display("FAIL reset5_outputs: got %0h want 0", {rp5, en5, sel5, v5, d5, idx5, m5, busy5, done5});
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int e0, e1, r, mr;
    bit got;
    eval_time = 16'd4; rep_log2 = 3'd2; cnt_in = {16'd20, 16'd10}; resp_ready = 1'b1;
    start8 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      run_grp(0, 200, e0, e1, r, mr, got);
      if (g == 0) start8 = 1'b0;
      chk_cnt++;
      if (!got || e0 != 16 || e1 != 16 || r != 4 || mr != 4)
        $display("FAIL basic_activity g%0d: got valid=%0d en0=%0d en1=%0d rst=%0d run=%0d want 1/16/16/4/4", g, got, e0, e1, r, mr);
      else pass_cnt++;
      chk_cnt++;
      if (d8 !== {16'd20, 16'd10} || idx8 !== 3'(2 * g) || m8 !== 2'b11)
        $display("FAIL basic_resp g%0d: got data=%h idx=%0d mask=%b want 0014000a/%0d/11", g, d8, idx8, m8, 2 * g);
      else pass_cnt++;
    end
    for (int c = 0; c < 10 && !done8; c++) @(negedge clk);
    chk_cnt++;
    if (done8 !== 1'b1 || busy8 !== 1'b0)
      $display("FAIL basic_done: got done=%b busy=%b want 1/0", done8, busy8);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done8 !== 1'b0)
      $display("FAIL basic_done_drop: got done=%b want 0", done8);
    else pass_cnt++;
  endtask

  task automatic test_partial;
    int e0, e1, r, mr;
    bit got;
    eval_time = 16'd4; rep_log2 = 3'd2; cnt_in = {16'd20, 16'd10}; resp_ready = 1'b1;
    start5 = 1'b1;
    for (int g = 0; g < 3; g++) begin
      run_grp(1, 200, e0, e1, r, mr, got);
      if (g == 0) start5 = 1'b0;
      if (g < 2) begin
        chk_cnt++;
        if (!got || idx5 !== 3'(2 * g) || m5 !== 2'b11 || d5 !== {16'd20, 16'd10})
          $display("FAIL partial_full g%0d: got valid=%0d idx=%0d mask=%b data=%h want 1/%0d/11/0014000a", g, got, idx5, m5, d5, 2 * g);
        else pass_cnt++;
      end else begin
        chk_cnt++;
        if (!got || idx5 !== 3'd4 || m5 !== 2'b01 || d5 !== {16'd0, 16'd10})
          $display("FAIL partial_last: got valid=%0d idx=%0d mask=%b data=%h want 1/4/01/0000000a", got, idx5, m5, d5);
        else pass_cnt++;
        chk_cnt++;
        if (e1 != 0 || e0 != 16)
          $display("FAIL partial_enable: got en0=%0d en1=%0d want 16/0", e0, e1);
        else pass_cnt++;
      end
    end
    for (int c = 0; c < 10 && !done5; c++) @(negedge clk);
    chk_cnt++;
    if (done5 !== 1'b1)
      $display("FAIL partial_done: got done=%b want 1", done5);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int e0, e1, r, mr, bad;
    bit got;
    logic [31:0] cap_d;
    logic [2:0]  cap_i;
    eval_time = 16'd4; rep_log2 = 3'd2; cnt_in = {16'd20, 16'd10}; resp_ready = 1'b0;
    start8 = 1'b1;
    run_grp(0, 200, e0, e1, r, mr, got);
    start8 = 1'b0;
    cap_d = d8; cap_i = idx8;
    cnt_in = 32'hDEAD_BEEF;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!v8 || d8 !== cap_d || idx8 !== cap_i || rp8 || en8 !== 2'b00 || m8 !== 2'b11) bad++;
    end
    chk_cnt++;
    if (!got || bad != 0 || cap_d !== {16'd20, 16'd10})
      $display("FAIL stall_stable: got valid=%0d bad=%0d data=%h want 1/0/0014000a", got, bad, cap_d);
    else pass_cnt++;
    resp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (v8 !== 1'b0)
      $display("FAIL stall_release: got valid=%b want 0", v8);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rp8 !== 1'b1 || sel8 !== 3'd2)
      $display("FAIL stall_next_group: got rst=%b sel=%0d want 1/2", rp8, sel8);
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cnt_in = {16'd20, 16'd10};
    @(negedge clk);
  endtask

  task automatic test_abort;
    int e0, e1, r, mr, n, bad;
    bit got, found;
    eval_time = 16'd4; rep_log2 = 3'd2; cnt_in = {16'd20, 16'd10}; resp_ready = 1'b1;
    start8 = 1'b1;
    run_grp(0, 200, e0, e1, r, mr, got);
    start8 = 1'b0;
    n = 0; found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rp8 && sel8 == 3'd2) n++;
      if (n == 3 && en8 !== 2'b00) begin found = 1; break; end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_cnt++;
    if (!found || busy8 !== 1'b0 || rp8 !== 1'b1 || en8 !== 2'b00 || v8 !== 1'b0)
      $display("FAIL abort_eval: got found=%0d busy=%b rst=%b en=%b valid=%b want 1/0/1/00/0", found, busy8, rp8, en8, v8);
    else pass_cnt++;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rp8 || v8 || busy8) bad++;
    end
    chk_cnt++;
    if (bad != 0)
      $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
    else pass_cnt++;
    start8 = 1'b1;
    run_grp(0, 200, e0, e1, r, mr, got);
    start8 = 1'b0;
    chk_cnt++;
    if (!got || idx8 !== 3'd0 || d8 !== {16'd20, 16'd10})
      $display("FAIL abort_restart: got valid=%0d idx=%0d data=%h want 1/0/0014000a", got, idx8, d8);
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_cnt++;
    if (v8 !== 1'b0 || busy8 !== 1'b0 || sel8 !== 3'd0 || rp8 !== 1'b1)
      $display("FAIL abort_vs_handshake: got valid=%b busy=%b sel=%0d rst=%b want 0/0/0/1", v8, busy8, sel8, rp8);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_min_and_max;
    int e0, e1, r, mr;
    bit got;
    eval_time = 16'd0; rep_log2 = 3'd0; cnt_in = {16'h1234, 16'h00AB}; resp_ready = 1'b1;
    start8 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      run_grp(0, 50, e0, e1, r, mr, got);
      if (g == 0) begin
        start8 = 1'b0;
        eval_time = 16'd9;
        rep_log2 = 3'd1;
      end
      chk_cnt++;
      if (!got || e0 != 1 || e1 != 1 || r != 1 || d8 !== {16'h1234, 16'h00AB} || idx8 !== 3'(2 * g))
        $display("FAIL min_cfg g%0d: got valid=%0d en0=%0d en1=%0d rst=%0d data=%h idx=%0d want 1/1/1/1/123400ab/%0d", g, got, e0, e1, r, d8, idx8, 2 * g);
      else pass_cnt++;
    end
    for (int c = 0; c < 10 && !done8; c++) @(negedge clk);
    @(negedge clk);
    eval_time = 16'd1; rep_log2 = 3'd7; cnt_in = 32'hFFFF_FFFF;
    start8 = 1'b1;
    run_grp(0, 1000, e0, e1, r, mr, got);
    start8 = 1'b0;
    chk_cnt++;
    if (!got || e0 != 128 || r != 128 || d8 !== 32'hFFFF_FFFF)
      $display("FAIL max_reps: got valid=%0d en0=%0d rst=%0d data=%h want 1/128/128/ffffffff", got, e0, r, d8);
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_held;
    int bad;
    eval_time = 16'd1; rep_log2 = 3'd0; cnt_in = {16'd3, 16'd4}; resp_ready = 1'b1;
    start8 = 1'b1;
    for (int c = 0; c < 100 && !done8; c++) @(negedge clk);
    chk_cnt++;
    if (done8 !== 1'b1)
      $display("FAIL held_done: got done=%b want 1", done8);
    else pass_cnt++;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy8 || rp8 || !done8) bad++;
    end
    chk_cnt++;
    if (bad != 0)
      $display("FAIL held_no_retrigger: got %0d bad cycles want 0", bad);
    else pass_cnt++;
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (done8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL held_release: got done=%b busy=%b want 0/0", done8, busy8);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit seen;
    eval_time = 16'd6; rep_log2 = 3'd1; resp_ready = 1'b1;
    start8 = 1'b1;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (en8 !== 2'b00) begin seen = 1; break; end
    end
    start8 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (!seen || {rp8, en8, sel8, v8, d8, idx8, m8, busy8, done8} !== 46'd0)
      $display("FAIL reset_mid: got seen=%0d outputs=%h want 1/0", seen, {rp8, en8, sel8, v8, d8, idx8, m8, busy8, done8});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start8 = 1'b0; start5 = 1'b0; abort = 1'b0; resp_ready = 1'b0;
    eval_time = '0; rep_log2 = '0; cnt_in = '0;
    test_reset;
    test_basic;
    test_partial;
    test_backpressure;
    test_abort;
    test_min_and_max;
    test_start_held;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
